// File: rtl/clock_gate_pkg.sv
// Shared definitions for the clock gate controller: state encoding and the
// helper that sizes the shared drain/settle counter.
package clock_gate_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } cg_state_e;

  // Counter must hold both the drain timeout and the settle length.
  function automatic int cnt_width(input int timeout, input int settle);
    int a;
    int b;
    a = $clog2(timeout + 1);
    b = $clog2(settle + 1);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_gate_timer.sv
// Saturating cycle counter with synchronous clear and terminal compare.
// Ports:
//   clock, reset : free-running clock, asynchronous active-high reset
//   clear        : restart the count from zero on the next edge
//   term         : terminal value compared against the current count
//   done         : current count equals term
module clock_gate_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  // Holds at all-ones instead of wrapping so a disabled timeout never
  // produces a spurious terminal match after rollover.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock gate controller: drains the gated domain on a stop request, turns the
// gated clock off once the domain is idle, and restarts it with a settle
// period when requests drop or a wake interrupt arrives.
// Ports:
//   clock, reset : free-running clock, asynchronous active-high reset
//   stop_req     : per-requester level request to stop the gated clock
//   stop_ack     : per-requester acknowledge, valid only while clock is off
//   wake_irq     : level wake source overriding all stop requests
//   quiesce_req  : asks the gated domain to drain outstanding work
//   quiesce_ack  : gated domain reports idle (only honoured while draining)
//   clock_en     : registered enable for the system clock gate
//   state        : current FSM state (RUN=0, DRAIN=1, OFF=2, WAKE=3)
//   timeout_err  : one-cycle pulse when a drain times out
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int SETTLE  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   stop_req,
  output logic [N_REQ-1:0]   stop_ack,
  input  logic               wake_irq,
  output logic               quiesce_req,
  input  logic               quiesce_ack,
  output logic               clock_en,
  output logic [STATE_W-1:0] state,
  output logic               timeout_err
);

  localparam int CW = cnt_width(TIMEOUT, SETTLE);
  localparam logic [CW-1:0] TO_TERM = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] ST_TERM = CW'(SETTLE - 1);

  cg_state_e      state_q;
  cg_state_e      state_d;
  logic           blk_q;
  logic           timeout_hit;
  logic           cnt_done;
  logic [CW-1:0]  cnt_term;
  logic           any_req;

  assign any_req = |stop_req;

  // One counter serves both the drain timeout and the wake settle period.
  assign cnt_term = (state_q == ST_DRAIN) ? TO_TERM : ST_TERM;

  clock_gate_timer #(
    .W (CW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_d != state_q),
    .term  (cnt_term),
    .done  (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // blk_q keeps a timed-out requester from re-entering drain
        // until every request has been seen low.
        if (any_req && !wake_irq && !blk_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Abort wins over a same-cycle quiesce_ack.
        if (!any_req || wake_irq) begin
          state_d = ST_RUN;
        end else if (quiesce_ack) begin
          state_d = ST_OFF;
        end else if ((TIMEOUT != 0) && cnt_done) begin
          state_d     = ST_RUN;
          timeout_hit = 1'b1;
        end
      end
      ST_OFF: begin
        if (!any_req || wake_irq) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (cnt_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      clock_en    <= 1'b1;
      quiesce_req <= 1'b0;
      stop_ack    <= '0;
      timeout_err <= 1'b0;
      blk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clock_en    <= (state_d != ST_OFF);
      quiesce_req <= (state_d != ST_RUN);
      stop_ack    <= (state_d == ST_OFF) ? stop_req : '0;
      timeout_err <= timeout_hit;
      if (timeout_hit) begin
        blk_q <= 1'b1;
      end else if (!any_req) begin
        blk_q <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Testbench for clock_gate_ctrl: directed scenarios followed by randomized
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_clock_gate_ctrl;

  localparam int NR  = 4;
  localparam int TMO = 16;
  localparam int SET = 8;

  logic          clock;
  logic          reset;
  logic [NR-1:0] stop_req;
  logic [NR-1:0] stop_ack;
  logic          wake_irq;
  logic          quiesce_req;
  logic          quiesce_ack;
  logic          clock_en;
  logic [1:0]    state;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase 0=RUN 1=DRAIN 2=OFF 3=WAKE, age = cycles in phase.
  int            m_ph;
  int            m_age;
  bit            m_blk;
  bit            m_terr;
  logic [NR-1:0] m_ack;

  clock_gate_ctrl #(
    .N_REQ   (NR),
    .TIMEOUT (TMO),
    .SETTLE  (SET)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stop_req    (stop_req),
    .stop_ack    (stop_ack),
    .wake_irq    (wake_irq),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .clock_en    (clock_en),
    .state       (state),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph   = 0;
    m_age  = 0;
    m_blk  = 1'b0;
    m_terr = 1'b0;
    m_ack  = '0;
  endtask

  task automatic model_step();
    int nph;
    bit tmo;
    bit none;
    nph  = m_ph;
    tmo  = 1'b0;
    none = (stop_req == '0);
    case (m_ph)
      0: if (!none && !wake_irq && !m_blk) nph = 1;
      1: begin
        if (none || wake_irq) nph = 0;
        else if (quiesce_ack) nph = 2;
        else if (m_age + 1 == TMO) begin
          nph = 0;
          tmo = 1'b1;
        end
      end
      2: if (none || wake_irq) nph = 3;
      default: if (m_age + 1 == SET) nph = 0;
    endcase
    m_ack  = (nph == 2) ? stop_req : '0;
    m_terr = tmo;
    if (tmo) m_blk = 1'b1;
    else if (none) m_blk = 1'b0;
    m_age = (nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
  endtask

  // Advance one cycle: the model consumes the inputs the DUT just sampled,
  // then every output is compared.
  task automatic tick();
    @(negedge clock);
    if (reset) model_reset();
    else model_step();
    chk("state", 32'(state), 32'(m_ph));
    chk("clock_en", 32'(clock_en), 32'(m_ph != 2));
    chk("quiesce_req", 32'(quiesce_req), 32'(m_ph != 0));
    chk("stop_ack", 32'(stop_ack), 32'(m_ack));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic wait_run(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (state == 2'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  int n_drain;
  int n_wake;
  int n_terr;

  initial begin
    reset       = 1'b1;
    stop_req    = '0;
    wake_irq    = 1'b0;
    quiesce_ack = 1'b0;
    model_reset();
    tick();
    reset = 1'b0;
    tick();

    // Nominal stop with ack three cycles into drain.
    stop_req = 4'b0010;
    n_drain  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state == 2'd1) n_drain++;
    end
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    chk("nominal_drain_cycles", 32'(n_drain), 32'd3);
    chk("nominal_clock_en", 32'(clock_en), 32'd0);
    chk("nominal_stop_ack", 32'(stop_ack), 32'b0010);

    // Wake by dropping requests: settle then run.
    stop_req = '0;
    n_wake   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 2'd3) n_wake++;
      else break;
    end
    chk("wake_cycles", 32'(n_wake), 32'(SET));
    chk("wake_quiesce_req", 32'(quiesce_req), 32'd0);

    // Two requesters: partial release stays off.
    stop_req = 4'b0011;
    tick();
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    chk("multi_ack_both", 32'(stop_ack), 32'b0011);
    stop_req = 4'b0010;
    tick();
    chk("multi_partial_state", 32'(state), 32'd2);
    chk("multi_partial_ack", 32'(stop_ack), 32'b0010);
    stop_req = '0;
    tick();
    chk("multi_wake_state", 32'(state), 32'd3);
    wait_run("multi_wake_done");

    // Drain timeout with a held request.
    stop_req = 4'b0001;
    n_drain  = 0;
    n_terr   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state == 2'd1) n_drain++;
      if (timeout_err) n_terr++;
    end
    chk("timeout_drain_cycles", 32'(n_drain), 32'(TMO));
    chk("timeout_pulses", 32'(n_terr), 32'd1);
    chk("timeout_blocked_state", 32'(state), 32'd0);
    stop_req = '0;
    tick();

    // Wake and ack together in drain: abort wins.
    stop_req = 4'b0100;
    tick();
    wake_irq    = 1'b1;
    quiesce_ack = 1'b1;
    tick();
    chk("simul_state", 32'(state), 32'd0);
    chk("simul_clock_en", 32'(clock_en), 32'd1);
    wake_irq    = 1'b0;
    quiesce_ack = 1'b0;
    stop_req    = '0;
    tick();

    // Asynchronous reset while off.
    stop_req = 4'b1000;
    tick();
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    chk("areset_pre_off", 32'(clock_en), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("areset_clock_en", 32'(clock_en), 32'd1);
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_stop_ack", 32'(stop_ack), 32'd0);
    stop_req = '0;
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic with sticky stop requests.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(2) == 0) stop_req = '0;
        else stop_req = NR'($urandom);
      end
      wake_irq    = ($urandom_range(15) == 0);
      quiesce_ack = ($urandom_range(3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of stop requesters (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum DRAIN cycles before abort; 0 disables the timeout.
REQ-003 SHALL have parameter SETTLE, default 8, number of WAKE cycles with the clock enabled before RUN (1..255).
REQ-004 SHALL have port clock, input, 1, free-running clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port stop_req, input, N_REQ, level request per requester to stop the gated clock.
REQ-007 SHALL have port stop_ack, output, N_REQ, per-requester acknowledge that the clock is stopped.
REQ-008 SHALL have port wake_irq, input, 1, level wake source overriding all stop requests.
REQ-009 SHALL have port quiesce_req, output, 1, request to the gated domain to drain outstanding work.
REQ-010 SHALL have port quiesce_ack, input, 1, gated domain reports idle.
REQ-011 SHALL have port clock_en, output, 1, registered enable driven to the system clock gate.
REQ-012 SHALL have port state, output, 2, current FSM state encoding.
REQ-013 SHALL have port timeout_err, output, 1, one-cycle pulse on DRAIN timeout.

Function
REQ-014 SHALL implement FSM states RUN=0, DRAIN=1, OFF=2, WAKE=3; all outputs registered.
REQ-015 RUN: clock_en=1, quiesce_req=0; if (|stop_req) && !wake_irq, SHALL go to DRAIN next cycle.
REQ-016 DRAIN: quiesce_req=1, clock_en=1; timeout counter increments each cycle from 0.
REQ-017 DRAIN with quiesce_ack=1 SHALL go to OFF; clock_en falls on the first OFF cycle.
REQ-018 DRAIN with stop_req==0 or wake_irq=1 SHALL go to RUN (abort) and takes priority over quiesce_ack in the same cycle.
REQ-019 DRAIN with TIMEOUT!=0 and counter==TIMEOUT-1 without ack or abort SHALL go to RUN and pulse timeout_err for exactly one cycle.
REQ-020 After a timeout, RUN SHALL NOT re-enter DRAIN until stop_req has been observed all-zero for at least one cycle.
REQ-021 OFF: clock_en=0, quiesce_req=1; stop_ack[i] SHALL equal stop_req[i] registered, and is 0 in every other state.
REQ-022 OFF with stop_req==0 or wake_irq=1 SHALL go to WAKE; stop_ack SHALL drop in the same cycle clock_en rises.
REQ-023 WAKE: clock_en=1, quiesce_req=1 for SETTLE cycles, then RUN with quiesce_req=0; stop requests arriving in WAKE are not sampled until RUN.
REQ-024 Counter width SHALL be max($clog2(TIMEOUT+1), $clog2(SETTLE+1)); it SHALL clear on every state change and SHALL NOT wrap.
REQ-025 quiesce_ack outside DRAIN SHALL be ignored.

Reset
REQ-026 Reset SHALL asynchronously force state=RUN, clock_en=1, quiesce_req=0, stop_ack=0, timeout_err=0, counter=0, timeout block flag=0.
REQ-027 Reset asserted in OFF SHALL re-enable the clock immediately, without a WAKE settle period.

Structure
REQ-028 The state enum, its width, and encodings SHALL live in package clock_gate_pkg.
REQ-029 A single sub-module clock_gate_timer (load-clear, count, terminal-compare) SHALL be used for the TIMEOUT and SETTLE counts.

Verification
REQ-030 Nominal stop: stop_req=4'b0010 with quiesce_ack 3 cycles later -> DRAIN 3 cycles, OFF, clock_en=0, stop_ack=4'b0010.
REQ-031 Wake: in OFF, drop stop_req -> WAKE for 8 cycles with clock_en=1, then RUN with quiesce_req=0.
REQ-032 Timeout: TIMEOUT=16, no ack -> RUN after 16 DRAIN cycles and a single timeout_err pulse; a held stop_req does not re-enter DRAIN.
REQ-033 Simultaneous: in DRAIN, wake_irq=1 and quiesce_ack=1 in the same cycle -> RUN, clock_en stays 1.
REQ-034 Async reset in OFF mid-cycle -> clock_en=1 and state=RUN before the next clock edge.
REQ-035 Multi-requester: stop_req=4'b0011 in OFF, then drop bit 0 -> remain OFF with stop_ack=4'b0010; then drop bit 1 -> WAKE.
